// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// The state list includes BREAK_WAIT; it is only entered when UART_RX_BREAK_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_W_MAX     = 9;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned MAJ_LO         = OVERSAMPLE_DEF / 2 - 1;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic [DATA_W_MAX-1:0] data;
    logic                  parity_err;
    logic                  frame_err;
  } rx_word_t;

  function automatic int unsigned maj_lo(input int unsigned os);
    return os / 2 - 1;
  endfunction

  // Encoding 11 is reserved and behaves as no parity.
  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word delivery bus: valid/ready holding register with error flags and overrun pulse.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS_MAX = 9
);
  logic [DATA_BITS_MAX-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     rx_parity_err;
  logic                     rx_frame_err;
  logic                     rx_overrun;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_os_sampler.sv
// Line synchroniser, baud tick divider, per-bit tick index and 3-sample majority vote.
module uart_os_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_line,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             run,
  output logic             line_sync,
  output logic             fall_edge,
  output logic             tick,
  output logic             bit_strobe,
  output logic             bit_val
);
  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam int unsigned LO    = maj_lo(OVERSAMPLE);

  logic             sync1, sync2, line_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] tick_idx;
  logic             samp0, samp1;

  assign line_sync  = sync2;
  assign fall_edge  = line_prev & ~sync2;
  assign tick       = run && (div_cnt == baud_div);
  assign bit_strobe = tick && (tick_idx == IDX_W'(LO + 2));
  assign bit_val    = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      div_cnt   <= '0;
      tick_idx  <= '0;
      samp0     <= 1'b0;
      samp1     <= 1'b0;
    end else begin
      sync1     <= rx_line;
      sync2     <= sync1;
      line_prev <= sync2;
      if (!run) begin
        div_cnt  <= '0;
        tick_idx <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        tick_idx <= (tick_idx == IDX_W'(OVERSAMPLE - 1)) ? '0 : tick_idx + 1'b1;
        if (tick_idx == IDX_W'(LO))     samp0 <= sync2;
        if (tick_idx == IDX_W'(LO + 1)) samp1 <= sync2;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..9 data bits, parity, 1/2 stop bits).
// Optional break detection is enabled with the UART_RX_BREAK_EN macro.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS_MAX = 9,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned DIV_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_line,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop_bits2,
  uart_rx_cfg_if.master    rx_if,
  output logic             rx_busy,
  output logic             rx_break
);
  localparam int unsigned HI_W = $clog2(OVERSAMPLE) + 1;

  rx_state_t             state_q, state_n;
  logic                  line_sync, fall_edge, tick, bit_strobe, bit_val;
  logic [3:0]            bit_cnt_q, cfg_bits_q, bits_clamped;
  parity_mode_t          cfg_par_q;
  logic                  cfg_stop2_q;
  logic [DATA_W_MAX-1:0] shift_q;
  logic                  par_acc_q, perr_q, ferr_q, zero_q;
  logic [HI_W-1:0]       hi_cnt_q;
  logic                  frame_done;
  rx_word_t              word_n;
`ifdef UART_RX_BREAK_EN
  logic                  break_det;
`endif

  uart_os_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_W     (DIV_W)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .rx_line   (rx_line),
    .baud_div  (baud_div),
    .run       (state_q != IDLE),
    .line_sync (line_sync),
    .fall_edge (fall_edge),
    .tick      (tick),
    .bit_strobe(bit_strobe),
    .bit_val   (bit_val)
  );

  always_comb begin
    bits_clamped = data_bits;
    if (data_bits < 4'd5)                 bits_clamped = 4'd5;
    if (data_bits > 4'(DATA_BITS_MAX))    bits_clamped = 4'(DATA_BITS_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    frame_done = 1'b0;
`ifdef UART_RX_BREAK_EN
    break_det  = 1'b0;
`endif
    unique case (state_q)
      IDLE:   if (fall_edge) state_n = START;
      START:  if (bit_strobe) state_n = bit_val ? IDLE : DATA;
      DATA:   if (bit_strobe && (bit_cnt_q == cfg_bits_q - 4'd1))
                state_n = (cfg_par_q != PAR_NONE) ? PARITY : STOP1;
      PARITY: if (bit_strobe) state_n = STOP1;
      STOP1: begin
        if (bit_strobe) begin
`ifdef UART_RX_BREAK_EN
          if (zero_q && !bit_val) begin
            break_det = 1'b1;
            state_n   = BREAK_WAIT;
          end else
`endif
          if (cfg_stop2_q) begin
            state_n = STOP2;
          end else begin
            state_n    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bit_strobe) begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
      end
      BREAK_WAIT: if (tick && line_sync && hi_cnt_q == HI_W'(OVERSAMPLE - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The final stop bit's own sample is folded in here since completion is in the same cycle.
  always_comb begin
    word_n            = '0;
    word_n.data       = shift_q;
    word_n.parity_err = perr_q;
    word_n.frame_err  = ferr_q | ~bit_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      cfg_bits_q  <= 4'd8;
      cfg_par_q   <= PAR_NONE;
      cfg_stop2_q <= 1'b0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      zero_q      <= 1'b0;
      hi_cnt_q    <= '0;
    end else begin
      if (state_q == IDLE && fall_edge) begin
        cfg_bits_q  <= bits_clamped;
        cfg_par_q   <= decode_parity(parity_mode);
        cfg_stop2_q <= stop_bits2;
        bit_cnt_q   <= '0;
        shift_q     <= '0;
        par_acc_q   <= 1'b0;
        perr_q      <= 1'b0;
        ferr_q      <= 1'b0;
        zero_q      <= 1'b1;
      end else if (bit_strobe) begin
        case (state_q)
          DATA: begin
            shift_q[bit_cnt_q] <= bit_val;
            bit_cnt_q          <= bit_cnt_q + 1'b1;
            par_acc_q          <= par_acc_q ^ bit_val;
            zero_q             <= zero_q & ~bit_val;
          end
          PARITY: begin
            perr_q <= (par_acc_q ^ bit_val) != (cfg_par_q == PAR_ODD);
            zero_q <= zero_q & ~bit_val;
          end
          STOP1, STOP2: ferr_q <= ferr_q | ~bit_val;
          default: ;
        endcase
      end
      if (state_q != BREAK_WAIT || !line_sync) hi_cnt_q <= '0;
      else if (tick)                           hi_cnt_q <= hi_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_if.rx_data       <= '0;
      rx_if.rx_valid      <= 1'b0;
      rx_if.rx_parity_err <= 1'b0;
      rx_if.rx_frame_err  <= 1'b0;
      rx_if.rx_overrun    <= 1'b0;
      rx_busy             <= 1'b0;
    end else begin
      rx_busy          <= (state_n != IDLE);
      rx_if.rx_overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_if.rx_valid || rx_if.rx_ready) begin
          rx_if.rx_data       <= word_n.data[DATA_BITS_MAX-1:0];
          rx_if.rx_parity_err <= word_n.parity_err;
          rx_if.rx_frame_err  <= word_n.frame_err;
          rx_if.rx_valid      <= 1'b1;
        end else begin
          rx_if.rx_overrun <= 1'b1;
        end
      end else if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_break <= 1'b0;
    else       rx_break <= break_det;
  end
`else
  assign rx_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames at baud_div=3 (64 clk per bit).
module tb_uart_rx_cfg;
  localparam int BIT_CLK = 64;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_line = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits2 = 1'b0;
  logic        rx_busy, rx_break;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  exp_t exp_q[$];

  uart_rx_cfg_if #(.DATA_BITS_MAX(9)) rx_if ();

  uart_rx_cfg #(
    .DATA_BITS_MAX(9),
    .OVERSAMPLE   (16),
    .DIV_W        (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_line    (rx_line),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop_bits2 (stop_bits2),
    .rx_if      (rx_if),
    .rx_busy    (rx_busy),
    .rx_break   (rx_break)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.rx_overrun) ovr_cnt++;
      if (rx_break) brk_cnt++;
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got data %0h with nothing expected", rx_if.rx_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_if.rx_data), 32'(e.data));
          check("rx_parity_err", 32'(rx_if.rx_parity_err), 32'(e.perr));
          check("rx_frame_err", 32'(rx_if.rx_frame_err), 32'(e.ferr));
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                            input logic par_bit, input logic stop_val, input bit two_stop);
    logic [8:0] d;
    d = data;
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stop_val);
    if (two_stop) drive_bit(1'b1);
    rx_line = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] pm, input logic s2);
    data_bits   = nb;
    parity_mode = pm;
    stop_bits2  = s2;
  endtask

  task automatic push_exp(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rx_if.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(rx_if.rx_valid), 32'd0);
    check("reset_data", 32'(rx_if.rx_data), 32'd0);
    check("reset_flags", {29'd0, rx_if.rx_parity_err, rx_if.rx_frame_err, rx_if.rx_overrun}, 32'd0);
    check("reset_busy_break", {30'd0, rx_busy, rx_break}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk); #1;

    set_cfg(4'd8, 2'b00, 1'b0);
    push_exp(9'h0A5, 1'b0, 1'b0);
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain("drain_8n1_a5");

    set_cfg(4'd7, 2'b01, 1'b1);
    push_exp(9'h055, 1'b1, 1'b0);
    send_frame(9'h055, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    push_exp(9'h055, 1'b0, 1'b0);
    send_frame(9'h055, 7, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_7e2");

    set_cfg(4'd8, 2'b00, 1'b0);
    push_exp(9'h03C, 1'b0, 1'b1);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain("drain_stop_err");

    set_cfg(4'd5, 2'b10, 1'b0);
    push_exp(9'h013, 1'b0, 1'b0);
    send_frame(9'h013, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    set_cfg(4'd9, 2'b11, 1'b0);
    push_exp(9'h155, 1'b0, 1'b0);
    send_frame(9'h155, 9, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain("drain_5o1_9n1");

    // False start: 20 clk low glitch
    set_cfg(4'd8, 2'b00, 1'b0);
    rx_line = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    repeat (10) @(posedge clk); #1;
    rx_line = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("glitch_busy_clear", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(rx_if.rx_valid), 32'd0);

    // Overrun with consumer stalled
    rx_if.rx_ready = 1'b0;
    base = ovr_cnt;
    push_exp(9'h011, 1'b0, 1'b0);
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("ovr_valid_held", 32'(rx_if.rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_if.rx_data), 32'h011);
    check("ovr_pulse_count", 32'(ovr_cnt - base), 32'd1);
    @(posedge clk); #1;
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_cleared", 32'(rx_if.rx_valid), 32'd0);
    wait_drain("drain_overrun");

    // Reset in the middle of the data bits
    rx_line = 1'b0;
    repeat (BIT_CLK * 4) @(posedge clk); #1;
    reset = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_busy", 32'(rx_busy), 32'd0);
    check("midreset_valid", 32'(rx_if.rx_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (50) @(posedge clk); #1;
    push_exp(9'h081, 1'b0, 1'b0);
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain("drain_after_reset");

    // Line held low for two frame times
    base = brk_cnt;
`ifndef UART_RX_BREAK_EN
    push_exp(9'h000, 1'b0, 1'b1);
`endif
    rx_line = 1'b0;
    repeat (BIT_CLK * 20) @(posedge clk); #1;
    rx_line = 1'b1;
    repeat (200) @(posedge clk); #1;
`ifdef UART_RX_BREAK_EN
    check("break_pulses", 32'(brk_cnt - base), 32'd1);
`else
    check("break_pulses", 32'(brk_cnt - base), 32'd0);
`endif
    check("break_busy_clear", 32'(rx_busy), 32'd0);
    wait_drain("drain_break");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
